// File: rtl/phase_seq_pkg.sv
// rtl/phase_seq_pkg.sv - shared state encoding for the phase sequencer
//
// Purpose: sequencer state type and its fixed encoding, which is also the
// value driven on phase_sequencer.seq_state.
// Ports: none (package).
package phase_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_WAIT = 2'd2,
    ST_HALTED    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ring_index.sv
// rtl/ring_index.sv - modulo-MOD index counter with enable and wrap flag
//
// Purpose: counts 0..MOD-1 on enabled edges and returns to 0 after MOD-1.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, index to 0
//   en   - advance the index on this edge
//   idx  - current index
//   wrap - high when an enabled edge will take idx from MOD-1 back to 0
module ring_index #(
  parameter int MOD = 3,
  localparam int IW = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          wrap
);

  localparam logic [IW-1:0] LAST = IW'(MOD - 1);

  assign wrap = en && (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (en) begin
      idx <= wrap ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - one-hot T-phase / W-step timing generator
//
// Purpose: sequences T_PHASES fast phases inside each of W_STEPS slow steps
// per instruction cycle, with stall, halt-at-boundary and single-step control.
// Optional feature macro: PHASE_SEQ_CYCLE_CNT_EN (when defined, cycle_count
// counts completed instruction cycles; otherwise it is tied to 0).
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   run          - leave IDLE when high
//   stall        - freeze phase/step indices this clock
//   halt_req     - go to HALTED at the next instruction boundary
//   step_mode    - pause in STEP_WAIT at every instruction boundary
//   step_go      - release one instruction from STEP_WAIT
//   t_phase      - one-hot T-phase strobe (zero outside RUN)
//   w_step       - one-hot W-step strobe (zero outside RUN)
//   instr_start  - first clock of an instruction cycle
//   cycle_end    - last clock of an instruction cycle
//   seq_state    - IDLE=0, RUN=1, STEP_WAIT=2, HALTED=3
//   cycle_count  - completed instruction cycles, modulo 2^CNT_W
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int T_PHASES = 3,
  parameter int W_STEPS  = 6,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                stall,
  input  logic                halt_req,
  input  logic                step_mode,
  input  logic                step_go,
  output logic [T_PHASES-1:0] t_phase,
  output logic [W_STEPS-1:0]  w_step,
  output logic                instr_start,
  output logic                cycle_end,
  output logic [1:0]          seq_state,
  output logic [CNT_W-1:0]    cycle_count
);

  localparam int TW = (T_PHASES > 1) ? $clog2(T_PHASES) : 1;
  localparam int WW = (W_STEPS > 1) ? $clog2(W_STEPS) : 1;

  seq_state_t    state;
  seq_state_t    state_next;
  logic          in_run;
  logic          t_en;
  logic          t_wrap;
  logic          w_wrap;
  logic [TW-1:0] t_idx;
  logic [WW-1:0] w_idx;
  logic          first_q;

  assign in_run = (state == ST_RUN);
  assign t_en   = in_run && !stall;

  // Indices only move in RUN and RUN is only left at a boundary, where both
  // have just wrapped, so they are already 0 whenever RUN is re-entered.
  ring_index #(.MOD(T_PHASES)) u_t_index (
    .clk  (clk),
    .rst  (rst),
    .en   (t_en),
    .idx  (t_idx),
    .wrap (t_wrap)
  );

  ring_index #(.MOD(W_STEPS)) u_w_index (
    .clk  (clk),
    .rst  (rst),
    .en   (t_wrap),
    .idx  (w_idx),
    .wrap (w_wrap)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; w_wrap is exactly the unstalled last clock of a cycle
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (run) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_wrap) begin
          if (halt_req)       state_next = ST_HALTED;
          else if (step_mode) state_next = ST_STEP_WAIT;
        end
      end
      ST_STEP_WAIT: begin
        if (halt_req)     state_next = ST_HALTED;
        else if (step_go) state_next = ST_RUN;
      end
      default: state_next = ST_HALTED;
    endcase
  end

  // Marks the clock right after an instruction is launched, so a stall in
  // that first clock cannot produce a second instr_start at indices 0/0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
    end else begin
      first_q <= (state_next == ST_RUN) && (!in_run || w_wrap);
    end
  end

  // Outputs
  always_comb begin
    t_phase     = '0;
    w_step      = '0;
    instr_start = first_q;
    cycle_end   = w_wrap;
    seq_state   = state;
    if (in_run) begin
      t_phase = T_PHASES'(1) << t_idx;
      w_step  = W_STEPS'(1) << w_idx;
    end
  end

`ifdef PHASE_SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (w_wrap) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign cycle_count = count_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench for phase_sequencer
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic stall = 1'b0;
  logic halt_req = 1'b0;
  logic step_mode = 1'b0;
  logic step_go = 1'b0;

  logic [2:0]  a_tp;
  logic [5:0]  a_ws;
  logic        a_is, a_ce;
  logic [1:0]  a_st;
  logic [31:0] a_cnt;

  logic [1:0]  b_tp;
  logic [3:0]  b_ws;
  logic        b_is, b_ce;
  logic [1:0]  b_st;
  logic [2:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_sequencer dut_a (
    .clk(clk), .rst(rst), .run(run), .stall(stall), .halt_req(halt_req),
    .step_mode(step_mode), .step_go(step_go), .t_phase(a_tp), .w_step(a_ws),
    .instr_start(a_is), .cycle_end(a_ce), .seq_state(a_st), .cycle_count(a_cnt)
  );

  phase_sequencer #(.T_PHASES(2), .W_STEPS(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .run(run), .stall(stall), .halt_req(halt_req),
    .step_mode(step_mode), .step_go(step_go), .t_phase(b_tp), .w_step(b_ws),
    .instr_start(b_is), .cycle_end(b_ce), .seq_state(b_st), .cycle_count(b_cnt)
  );

  // Reference model: one linear position 0..T*W-1 inside the instruction,
  // a mode (0 idle, 1 run, 2 step-wait, 3 halted) and a "first clock" flag.
  int          tp_n [2] = '{3, 2};
  int          ws_n [2] = '{6, 4};
  logic [31:0] mask [2] = '{32'hFFFF_FFFF, 32'h7};
  int          mode [2];
  int          pos  [2];
  bit          fresh[2];
  logic [31:0] cnt  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; pos[i] = 0; fresh[i] = 0; cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int len = tp_n[i] * ws_n[i];
      case (mode[i])
        0: if (run) begin mode[i] = 1; pos[i] = 0; fresh[i] = 1; end
        1: begin
          if (stall) begin
            fresh[i] = 0;
          end else if (pos[i] == len - 1) begin
            cnt[i] = cnt[i] + 1;
            pos[i] = 0;
            fresh[i] = 1;
            if (halt_req)       begin mode[i] = 3; fresh[i] = 0; end
            else if (step_mode) begin mode[i] = 2; fresh[i] = 0; end
          end else begin
            pos[i] = pos[i] + 1;
            fresh[i] = 0;
          end
        end
        2: begin
          if (halt_req)     mode[i] = 3;
          else if (step_go) begin mode[i] = 1; pos[i] = 0; fresh[i] = 1; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_tp, e_ws, e_cnt, o_tp, o_ws, o_cnt;
    logic        e_is, e_ce, o_is, o_ce;
    logic [1:0]  o_st;
    string       nm;
    for (int i = 0; i < 2; i++) begin
      nm    = (i == 0) ? "a" : "b";
      o_tp  = (i == 0) ? 32'(a_tp) : 32'(b_tp);
      o_ws  = (i == 0) ? 32'(a_ws) : 32'(b_ws);
      o_cnt = (i == 0) ? a_cnt : 32'(b_cnt);
      o_is  = (i == 0) ? a_is : b_is;
      o_ce  = (i == 0) ? a_ce : b_ce;
      o_st  = (i == 0) ? a_st : b_st;
      e_tp  = (mode[i] == 1) ? (32'd1 << (pos[i] % tp_n[i])) : 32'd0;
      e_ws  = (mode[i] == 1) ? (32'd1 << (pos[i] / tp_n[i])) : 32'd0;
      e_is  = (mode[i] == 1) && (pos[i] == 0) && fresh[i];
      e_ce  = (mode[i] == 1) && (pos[i] == tp_n[i] * ws_n[i] - 1) && !stall && !rst;
`ifdef PHASE_SEQ_CYCLE_CNT_EN
      e_cnt = cnt[i] & mask[i];
`else
      e_cnt = 32'd0;
`endif
      chk({nm, ".t_phase"},     o_tp, e_tp);
      chk({nm, ".w_step"},      o_ws, e_ws);
      chk({nm, ".instr_start"}, 32'(o_is), 32'(e_is));
      chk({nm, ".cycle_end"},   32'(o_ce), 32'(e_ce));
      chk({nm, ".seq_state"},   32'(o_st), 32'(mode[i]));
      chk({nm, ".cycle_count"}, o_cnt, e_cnt);
    end
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic step(input logic r, input logic s, input logic h,
                      input logic sm, input logic sg);
    @(negedge clk);
    run = r; stall = s; halt_req = h; step_mode = sm; step_go = sg;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
  endtask

  task automatic steps(input int n, input logic r, input logic s, input logic h,
                       input logic sm);
    for (int k = 0; k < n; k++) step(r, s, h, sm, 1'b0);
  endtask

  // Reset asserted mid-clock; outputs must return to reset values at once.
  task automatic do_reset();
    @(negedge clk);
    run = 0; stall = 0; halt_req = 0; step_mode = 0; step_go = 0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Free run
    do_reset();
    steps(40, 1, 0, 0, 0);

    // Stall at t=1, w=2 of the default instance
    do_reset();
    for (int k = 0; k < 50 && !(mode[0] == 1 && pos[0] == 7); k++) step(1, 0, 0, 0, 0);
    steps(5, 1, 1, 0, 0);
    steps(20, 1, 0, 0, 0);

    // Stall in the first clock of an instruction
    do_reset();
    step(1, 0, 0, 0, 0);
    steps(3, 1, 1, 0, 0);
    steps(20, 1, 0, 0, 0);

    // Halt request mid-instruction, then run toggling
    do_reset();
    steps(7, 1, 0, 0, 0);
    steps(15, 1, 0, 1, 0);
    for (int k = 0; k < 8; k++) step(k[0], 0, k[1], 0, 0);

    // Single-step mode
    do_reset();
    steps(24, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    steps(34, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    steps(25, 1, 0, 0, 1);
    step(0, 0, 1, 1, 0);
    steps(3, 0, 0, 0, 0);

    // Reset mid-instruction, restart
    do_reset();
    steps(10, 1, 0, 0, 0);
    do_reset();
    steps(20, 1, 0, 0, 0);

    // Counter wrap on the small instance: more than 8 instructions
    do_reset();
    steps(80, 1, 0, 0, 0);

    // Randomised mix
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised multi-cycle timing generator for the Y86 datapath. Produces the one-hot T-phase (fast) and W-step (slow) strobes that sequence fetch, register, ALU, memory and write-back, counting instruction cycles. Generalises fixed 3-phase/6-step generation to arbitrary depths, and adds stall, halt-at-boundary and single-step control. Sits between the free-running clock and the controller, ALU, memory and register file.

## Interface
- T_PHASES, 3, T-phases per W-step (≥2)
- W_STEPS, 6, W-steps per instruction cycle (≥2)
- CNT_W, 32, width of instruction-cycle counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; leaves IDLE when high
- stall  in  1  level; freezes phase/step indices for the cycle
- halt_req  in  1  level; halt at next instruction boundary
- step_mode  in  1  level; pause at every instruction boundary
- step_go  in  1  pulse; release one instruction from STEP_WAIT
- t_phase  out  T_PHASES  one-hot T-phase strobe
- w_step  out  W_STEPS  one-hot W-step strobe
- instr_start  out  1  high in first clock of each instruction cycle
- cycle_end  out  1  high in last clock of each instruction cycle
- seq_state  out  2  IDLE=0, RUN=1, STEP_WAIT=2, HALTED=3
- cycle_count  out  CNT_W  completed instruction cycles

## Operation
- States: IDLE, RUN, STEP_WAIT, HALTED.
- IDLE: run=1 → RUN at next edge, indices t=0, w=0.
- RUN: each edge with stall=0, t increments; t==T_PHASES-1 wraps to 0 and w increments; w==W_STEPS-1 with t wrap wraps w to 0 (instruction boundary).
- stall=1: t, w, outputs, counter hold; cycle_end forced 0.
- At boundary (cycle_end=1), priority: halt_req → HALTED; else step_mode → STEP_WAIT; else remain RUN.
- STEP_WAIT: step_go=1 → RUN with t=w=0; halt_req=1 (with or without step_go) → HALTED.
- HALTED: terminal; exit only via rst.
- t_phase = one-hot(t), w_step = one-hot(w) in RUN; all zero in other states.
- instr_start = RUN & t==0 & w==0 & not held over from stalled previous clock (stall does not duplicate pulse; asserted only in first clock at indices 0/0).
- cycle_end = RUN & t==T_PHASES-1 & w==W_STEPS-1 & !stall (combinational from registered state and stall).
- cycle_count increments by 1 on each edge where cycle_end=1; wraps modulo 2^CNT_W.
- halt_req, step_mode mid-instruction: no effect until boundary.

## Timing
- Reset values: seq_state=IDLE, t=w=0, t_phase=0, w_step=0, instr_start=0, cycle_end=0, cycle_count=0.
- rst asserted mid-instruction: immediate return to reset values; no partial strobes after.
- run sampled at edge k → t_phase[0], w_step[0], instr_start high during clock k+1.
- Unstalled instruction cycle: exactly T_PHASES×W_STEPS clocks (18 at defaults).
- Boundary → next instruction in RUN: zero gap clocks.
- STEP_WAIT: step_go at edge k → instr_start during clock k+1.
- halt_req at boundary edge → HALTED after that edge; strobes zero from next clock.

## Configuration
- PHASE_SEQ_CYCLE_CNT_EN defined: cycle_count register implemented as above.
- Undefined: no counter flops; cycle_count tied to 0; all other behaviour identical.

## Structure
- Package phase_seq_pkg: state encoding constants (IDLE/RUN/STEP_WAIT/HALTED), 2-bit state type.
- Sub-module ring_index (parameter MOD): modulo counter with enable, async reset, index output and wrap flag; instantiated for T (enable = RUN & !stall) and W (enable = T wrap).
- One-hot decode, FSM, counter in phase_sequencer.

## Test plan
- Reset, run=1 for 40 clocks, defaults → t_phase cycles 001/010/100, w_step advances every 3 clocks, cycle_end at clocks 18 and 36, cycle_count=2.
- stall=1 for 5 clocks at t=1,w=2 → strobes hold 5 clocks, cycle_end shifts from clock 18 to 23.
- halt_req raised at clock 7 → runs to clock 18, seq_state=3 at clock 19, strobes 0, cycle_count=1, run toggling has no effect.
- step_mode=1, step_go pulses at clocks 25 and 60 → each releases exactly 18 strobe clocks, STEP_WAIT between.
- rst pulse at clock 10 → all outputs reset immediately; run=1 restarts at t=w=0.
- T_PHASES=2, W_STEPS=4, CNT_W=3, PHASE_SEQ_CYCLE_CNT_EN defined, 9 instructions → cycle_end every 8 clocks, cycle_count wraps 7→0→1; undefined build → cycle_count constant 0.
